ysyx_23060203_inst_queue: RTL and testbench

Decoupling instruction queue between the fetch stage (IFU) and the decode stage (IDU). It absorbs IFU fetch bursts while IDU/EXU stall, so ICache hits keep streaming. It presents the oldest buffered instruction to decode through a valid/ready handshake. On a redirect (jump or CSR/trap flush) it discards every buffered entry in one cycle.

---
 rtl/ysyx_23060203_inst_queue.sv | 126 ++++++++++++
 tb/tb_ysyx_23060203_inst_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_inst_queue.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_inst_queue
//
// Decoupling FIFO between fetch (IFU) and decode (IDU). It soaks up fetch
// bursts while the back end stalls, presents the oldest instruction to decode
// through a valid/ready handshake, and drops everything on a redirect.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset (clears pointers, count, storage)
//   flush      redirect pulse (jump_flush | cs_flush); empties the queue
//   in_valid   IFU has an instruction
//   in_ready   queue has a free slot (independent of out_ready)
//   in_pc      PC of incoming instruction
//   in_inst    incoming instruction word
//   out_valid  head entry is valid (masked during flush)
//   out_ready  IDU takes the head entry
//   out_pc     PC of head entry
//   out_inst   instruction word of head entry
//   count      occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ysyx_23060203_inst_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // in_ready deliberately ignores out_ready: a full queue refuses a push even
  // in a cycle that pops, which keeps the ready path free of IDU timing.
  assign in_ready  = ~full;
  assign out_valid = ~empty & ~flush;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  // No bypass: head data always comes from storage.
  assign out_pc   = pc_mem[head];
  assign out_inst = inst_mem[head];
  assign count    = cnt;

  // Pointer and occupancy control. Flush wins over push and pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage. Not cleared on flush; stale entries are simply unreachable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[tail]   <= in_pc;
      inst_mem[tail] <= in_inst;
    end
  end

`ifndef SYNTHESIS
  // Performance event counters, visible hierarchically in simulation.
  logic [63:0] perf_iq_full_cnt;
  logic [63:0] perf_iq_empty_cnt;
  logic [63:0] perf_iq_pop_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_iq_full_cnt  <= '0;
      perf_iq_empty_cnt <= '0;
      perf_iq_pop_cnt   <= '0;
    end else begin
      if (full)  perf_iq_full_cnt  <= perf_iq_full_cnt + 64'd1;
      if (empty) perf_iq_empty_cnt <= perf_iq_empty_cnt + 64'd1;
      if (pop)   perf_iq_pop_cnt   <= perf_iq_pop_cnt + 64'd1;
    end
  end

  // Sink so the counters are not reported as dangling when nothing probes them.
  logic perf_unused;
  assign perf_unused = ^{perf_iq_full_cnt, perf_iq_empty_cnt, perf_iq_pop_cnt};
`endif

endmodule

// File: tb/tb_ysyx_23060203_inst_queue.sv
module tb_ysyx_23060203_inst_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_inst;
  logic [CNT_W-1:0] count;

  ysyx_23060203_inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int mcnt     = 0;            // model occupancy
  logic [63:0] exp_q [$];      // scoreboard of {pc, inst} in expected order

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT hands an entry to decode, compare against the
  // oldest expected entry.
  always @(negedge clock) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pop: got pc 0x%0h expected no entry at %0t", out_pc, $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("out_pc", {32'd0, out_pc}, {32'd0, e[63:32]});
        chk("out_inst", {32'd0, out_inst}, {32'd0, e[31:0]});
      end
    end
  end

  // One cycle of stimulus; called just after a falling edge.
  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic fl);
    logic push_e, pop_e;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, (mcnt < DEPTH)});
    chk("out_valid", {63'd0, out_valid}, {63'd0, ((mcnt != 0) && !fl)});
    chk("count", {{(64-CNT_W){1'b0}}, count}, 64'(mcnt));
    push_e = iv && (mcnt < DEPTH) && !fl;
    pop_e  = (mcnt != 0) && !fl && ordy;
    @(posedge clock);
    if (fl) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      if (push_e) exp_q.push_back({pc, inst});
      mcnt = mcnt + int'(push_e) - int'(pop_e);
    end
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_count", {{(64-CNT_W){1'b0}}, count}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // First push, one-cycle fill latency, then pop.
    step(1, 32'h8000_0000, 32'h0000_0013, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);

    // Fill with out_ready low for DEPTH+2 cycles; the last two are refused.
    for (int i = 0; i < DEPTH + 2; i++)
      step(1, 32'h0000_0100 + 32'(4 * i), 32'h1000_0000 + 32'(i), 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);

    // Sustained push+pop through pointer wrap.
    for (int i = 0; i < 3 * DEPTH; i++)
      step(1, 32'h8000_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);

    // Flush with three entries buffered, together with push and pop.
    for (int i = 0; i < 3; i++)
      step(1, 32'h0000_0200 + 32'(4 * i), 32'h3000_0000 + 32'(i), 0, 0);
    step(1, 32'h0000_0dead, 32'h0000_beef, 1, 1);
    step(1, 32'h0000_0300, 32'h3000_00aa, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);

    // Full queue: pop with a push in the same cycle; push lands next cycle.
    for (int i = 0; i < DEPTH; i++)
      step(1, 32'h0000_0400 + 32'(4 * i), 32'h4000_0000 + 32'(i), 0, 0);
    step(1, 32'h0000_0500, 32'h4000_00bb, 1, 0);
    step(1, 32'h0000_0500, 32'h4000_00bb, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);

    // Asynchronous reset between edges with two entries buffered.
    step(1, 32'h0000_0600, 32'h5000_0000, 0, 0);
    step(1, 32'h0000_0604, 32'h5000_0001, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_count", {{(64-CNT_W){1'b0}}, count}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    mcnt = 0;
    @(negedge clock);
    reset = 1'b0;
    step(1, 32'h0000_0700, 32'h6000_0000, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 0, 0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
